// File: rtl/cpu_port_decoder_pkg.sv
// Shared types for the CPU I/O port decoder: FSM states, channel limit,
// machine and turbo selectors, and the per-channel address compare.
package common;

    localparam int PORT_MAX_CH = 8;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        ACTIVE,
        HOLD
    } port_state_t;

    typedef enum logic [1:0] {
        MACHINE_48K,
        MACHINE_128K,
        MACHINE_PLUS3,
        MACHINE_PENTAGON
    } machine_t;

    typedef enum logic [1:0] {
        TURBO_3M5,
        TURBO_7M,
        TURBO_14M,
        TURBO_28M
    } turbo_t;

    function automatic logic port_hit(
        input logic [15:0] addr,
        input logic [15:0] match,
        input logic [15:0] mask
    );
        return (addr & mask) == (match & mask);
    endfunction

endpackage

// File: rtl/cpu_port_decoder_sync2.sv
// Two-flop synchroniser for one asynchronous control line,
// with a configurable reset value.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic sync
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

endmodule

// File: rtl/cpu_port_decoder.sv
// CPU I/O port decoder: synchronises the strobes, decodes the address
// into one channel and pulses a read/write strobe. CPU_PORT_WAIT_EN adds wait_n.
module cpu_port_decoder
    import common::*;
#(
    parameter int              N_CH        = 4,
    parameter logic [N_CH*16-1:0] MATCH    =
        {16'h00FE, 16'h7FFD, 16'hFFFD, 16'hBFFD},
    parameter logic [N_CH*16-1:0] MASK     =
        {16'h0001, 16'h8002, 16'hC002, 16'hC002},
    parameter int              WAIT_CYCLES = 2
) (
    input  logic            clk28,
    input  logic            rst_n,
    input  logic [15:0]     a,
    input  logic [7:0]      d,
    input  logic            iorq_n,
    input  logic            rd_n,
    input  logic            wr_n,
    input  logic            m1_n,
    input  logic            turbo,
    output logic [N_CH-1:0] rd_stb,
    output logic [N_CH-1:0] wr_stb,
    output logic [N_CH-1:0] hit,
    output logic [15:0]     port_addr,
    output logic [7:0]      port_wdata,
    output logic            busy
`ifdef CPU_PORT_WAIT_EN
   ,output logic            wait_n
`endif
);

    logic iorq_s;
    logic rd_s;
    logic wr_s;
    logic m1_s;

    sync2 #(.RST_VAL(1'b1)) u_sync_iorq (
        .clk(clk28), .rst_n(rst_n), .raw(iorq_n), .sync(iorq_s)
    );
    sync2 #(.RST_VAL(1'b1)) u_sync_rd (
        .clk(clk28), .rst_n(rst_n), .raw(rd_n), .sync(rd_s)
    );
    sync2 #(.RST_VAL(1'b1)) u_sync_wr (
        .clk(clk28), .rst_n(rst_n), .raw(wr_n), .sync(wr_s)
    );
    sync2 #(.RST_VAL(1'b1)) u_sync_m1 (
        .clk(clk28), .rst_n(rst_n), .raw(m1_n), .sync(m1_s)
    );

    port_state_t     state;
    logic            is_wr;
    logic            start;
    logic [N_CH-1:0] match_hit;

    // Plain I/O cycle only: no interrupt acknowledge, no rd+wr overlap.
    assign start = !iorq_s && m1_s && (rd_s ^ wr_s);
    assign busy  = (state != IDLE);

    // Scan downwards so the lowest matching channel wins.
    always_comb begin
        match_hit = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (port_hit(a, MATCH[i*16 +: 16], MASK[i*16 +: 16])) begin
                match_hit    = '0;
                match_hit[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            is_wr      <= 1'b0;
            hit        <= '0;
            rd_stb     <= '0;
            wr_stb     <= '0;
            port_addr  <= 16'h0000;
            port_wdata <= 8'h00;
        end else begin
            rd_stb <= '0;
            wr_stb <= '0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= DECODE;
                        is_wr <= !wr_s;
                    end
                end
                DECODE: begin
                    if (iorq_s) begin
                        state <= IDLE;
                        hit   <= '0;
                    end else begin
                        state      <= ACTIVE;
                        port_addr  <= a;
                        port_wdata <= d;
                        hit        <= match_hit;
                    end
                end
                ACTIVE: begin
                    state <= HOLD;
                    if (is_wr) wr_stb <= hit;
                    else       rd_stb <= hit;
                end
                HOLD: begin
                    if (iorq_s) begin
                        state <= IDLE;
                        hit   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CPU_PORT_WAIT_EN
    logic [3:0] wait_cnt;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            wait_n   <= 1'b1;
            wait_cnt <= 4'd0;
        end else if (state == IDLE && start && turbo) begin
            wait_n   <= 1'b0;
            wait_cnt <= 4'(WAIT_CYCLES - 1);
        end else if (state == DECODE && iorq_s) begin
            wait_n <= 1'b1;
        end else if (!wait_n) begin
            if (wait_cnt == 4'd0) wait_n   <= 1'b1;
            else                  wait_cnt <= wait_cnt - 4'd1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{turbo, 4'(WAIT_CYCLES)};
`endif

endmodule

// File: tb/tb_cpu_port_decoder.sv
// Randomised scoreboard bench for cpu_port_decoder; expected strobes come
// from a table-driven channel model and cycle arithmetic on the input edge.
module tb_cpu_port_decoder;

    localparam int N    = 4;
    localparam int WAIT = 2;

    // Per-channel view of the default decode table, channel 0 first.
    localparam logic [15:0] CH_MATCH [N] =
        '{16'hBFFD, 16'hFFFD, 16'h7FFD, 16'h00FE};
    localparam logic [15:0] CH_MASK  [N] =
        '{16'hC002, 16'hC002, 16'h8002, 16'h0001};

    logic          clk28 = 1'b0;
    logic          rst_n;
    logic [15:0]   a;
    logic [7:0]    d;
    logic          iorq_n, rd_n, wr_n, m1_n, turbo;
    logic [N-1:0]  rd_stb, wr_stb, hit;
    logic [15:0]   port_addr;
    logic [7:0]    port_wdata;
    logic          busy;
`ifdef CPU_PORT_WAIT_EN
    logic          wait_n;
`endif

    cpu_port_decoder dut (
        .clk28(clk28), .rst_n(rst_n), .a(a), .d(d),
        .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
        .turbo(turbo), .rd_stb(rd_stb), .wr_stb(wr_stb), .hit(hit),
        .port_addr(port_addr), .port_wdata(port_wdata), .busy(busy)
`ifdef CPU_PORT_WAIT_EN
       ,.wait_n(wait_n)
`endif
    );

    always #5 clk28 = ~clk28;

    typedef struct {
        int           cyc;
        logic [N-1:0] rd;
        logic [N-1:0] wr;
        logic [15:0]  adr;
        logic [7:0]   dat;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk28) cyc <= cyc + 1;

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endfunction

    function automatic int model_ch(input logic [15:0] adr);
        for (int i = 0; i < N; i++) begin
            if ((adr & CH_MASK[i]) == (CH_MATCH[i] & CH_MASK[i]))
                return i;
        end
        return -1;
    endfunction

    // Monitor: every strobe must correspond to a queued expectation.
    always @(negedge clk28) begin
        exp_t e;
        if ((rd_stb | wr_stb) != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {24'b0, rd_stb, wr_stb}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("stb_cycle", cyc, e.cyc);
                chk("rd_stb", {28'b0, rd_stb}, {28'b0, e.rd});
                chk("wr_stb", {28'b0, wr_stb}, {28'b0, e.wr});
                chk("port_addr", {16'b0, port_addr}, {16'b0, e.adr});
                chk("port_wdata", {24'b0, port_wdata}, {24'b0, e.dat});
            end
        end
    end

    task automatic do_reset();
        rst_n  = 1'b0;
        iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_hit", {28'b0, hit}, 32'h0);
        chk("rst_stb", {24'b0, rd_stb, wr_stb}, 32'h0);
        chk("rst_addr", {16'b0, port_addr}, 32'h0);
        chk("rst_wdata", {24'b0, port_wdata}, 32'h0);
`ifdef CPU_PORT_WAIT_EN
        chk("rst_wait_n", {31'b0, wait_n}, 32'h1);
`endif
        repeat (2) @(negedge clk28);
        rst_n = 1'b1;
        repeat (3) @(negedge clk28);
    endtask

    // kind: 0 read, 1 write, 2 interrupt ack, 3 rd+wr together.
    // rst_at: 0 none, 1 reset in DECODE, 2 reset in HOLD.
    task automatic txn(input int kind, input logic [15:0] adr,
                       input logic [7:0] dat, input int rst_at);
        int   c0, len, ch, nlow;
        logic go, seen_busy;
        logic [N-1:0] oh;
        exp_t e;
        @(negedge clk28);
        c0    = cyc;
        a     = adr;
        d     = dat;
        turbo = 1'($urandom_range(0, 1));
        go    = (kind < 2);
        ch    = model_ch(adr);
        oh    = (ch >= 0) ? N'(1 << ch) : '0;
        len   = $urandom_range(6, 10);
        nlow  = 0;
        seen_busy = 1'b0;
        iorq_n = 1'b0;
        m1_n   = (kind == 2) ? 1'b0 : 1'b1;
        rd_n   = (kind == 1) ? 1'b1 : 1'b0;
        wr_n   = (kind == 1 || kind == 3) ? 1'b0 : 1'b1;
        if (go && rst_at != 1 && ch >= 0) begin
            e.cyc = c0 + 5;
            e.rd  = (kind == 0) ? oh : '0;
            e.wr  = (kind == 1) ? oh : '0;
            e.adr = adr;
            e.dat = dat;
            sb.push_back(e);
        end
        for (int i = 1; i <= len; i++) begin
            @(negedge clk28);
            if (busy) seen_busy = 1'b1;
`ifdef CPU_PORT_WAIT_EN
            if (!wait_n) nlow++;
`endif
            if (i == 3 && rst_at == 1) begin
                do_reset();
                return;
            end
            if (i == 5) begin
                chk("hit_level", {28'b0, hit}, go ? {28'b0, oh} : 32'h0);
                chk("busy_active", {31'b0, busy}, {31'b0, go});
            end
            if (i == len && rst_at == 2) begin
                do_reset();
                return;
            end
        end
        iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
        @(negedge clk28);
        @(negedge clk28);
        chk("busy_hold", {31'b0, busy}, {31'b0, go});
        @(negedge clk28);
        chk("busy_fall", {31'b0, busy}, 32'h0);
        if (!go) chk("no_busy", {31'b0, seen_busy}, 32'h0);
`ifdef CPU_PORT_WAIT_EN
        chk("wait_len", nlow, (go && turbo) ? WAIT : 0);
`endif
        repeat (2) @(negedge clk28);
    endtask

    initial begin
        logic [15:0] pick [5];
        logic [15:0] adr;
        int          kind;
        pick = '{16'h00FE, 16'h7FFD, 16'hFFFD, 16'hBFFD, 16'h001F};
        rst_n  = 1'b0;
        a = 16'h0; d = 8'h0; turbo = 1'b0;
        iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
        repeat (2) @(negedge clk28);
        chk("init_busy", {31'b0, busy}, 32'h0);
        chk("init_hit", {28'b0, hit}, 32'h0);
        chk("init_addr", {16'b0, port_addr}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk28);

        txn(1, 16'h7FFD, 8'h17, 0);
        txn(0, 16'h00FE, 8'h00, 0);
        txn(2, 16'h00FE, 8'h00, 0);
        txn(3, 16'h7FFD, 8'h55, 0);
        txn(1, 16'h001F, 8'h3C, 0);
        txn(1, 16'hFFFD, 8'h07, 0);
        txn(1, 16'h7FFD, 8'hA5, 2);
        txn(0, 16'hBFFD, 8'h00, 1);
        txn(1, 16'h7FFD, 8'h17, 0);

        for (int n = 0; n < 40; n++) begin
            kind = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 1)
                                               : $urandom_range(2, 3);
            adr  = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                               : pick[$urandom_range(0, 4)];
            txn(kind, adr, 8'($urandom), 0);
        end

        repeat (10) @(negedge clk28);
        chk("sb_leftover", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
